// File: rtl/inst_ctrl.sv
// rtl/inst_ctrl.sv - multi-cycle fetch/decode/execute/mem/write-back sequencer for the RV32E core
module inst_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req,
    input  logic        ifu_ack,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] inst_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic [2:0]  funct3_o,
    output logic [6:0]  funct7_o,
    output logic [2:0]  type_o,
    output logic        lsu_req,
    output logic        lsu_we,
    input  logic        lsu_ack,
    input  logic        branch_taken,
    output logic        reg_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        halt,
    output logic        illegal,
    output logic [31:0] inst_cnt
);
    localparam logic [2:0] INST_R = 3'd1;
    localparam logic [2:0] INST_I = 3'd2;
    localparam logic [2:0] INST_S = 3'd3;
    localparam logic [2:0] INST_B = 3'd4;
    localparam logic [2:0] INST_U = 3'd5;
    localparam logic [2:0] INST_J = 3'd6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t      state;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [2:0]  dec_type;
    logic        dec_bad;
    logic        wb_reg_we;
    logic        wb_pc_sel;
    logic        is_mem;

    assign inst_o   = ir;
    assign opcode   = ir[6:0];
    assign rs1_o    = ir[19:15];
    assign rs2_o    = ir[24:20];
    assign rd_o     = ir[11:7];
    assign funct3_o = ir[14:12];
    assign funct7_o = ir[31:25];

    always_comb begin
        dec_type = 3'd0;
        case (opcode)
            OP_R:                               dec_type = INST_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: dec_type = INST_I;
            OP_STORE:                           dec_type = INST_S;
            OP_BRANCH:                          dec_type = INST_B;
            OP_LUI, OP_AUIPC:                   dec_type = INST_U;
            OP_JAL:                             dec_type = INST_J;
            default:                            dec_type = 3'd0;
        endcase
    end

    // RV32E has only x0-x15, so bit 4 of any used register field is illegal
    always_comb begin
        dec_bad = 1'b0;
        case (dec_type)
            INST_R:         dec_bad = ir[11] | ir[19] | ir[24];
            INST_I:         dec_bad = ir[11] | ir[19];
            INST_S, INST_B: dec_bad = ir[19] | ir[24];
            INST_U, INST_J: dec_bad = ir[11];
            default:        dec_bad = 1'b1;
        endcase
    end

    assign is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign wb_reg_we = (type_o != INST_S) && (type_o != INST_B) && (rd_o != 5'd0);
    assign wb_pc_sel = (type_o == INST_J) || (opcode == OP_JALR) ||
                       ((type_o == INST_B) && branch_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_RST;
            ir       <= 32'd0;
            type_o   <= 3'd0;
            inst_cnt <= 32'd0;
            ifu_req  <= 1'b0;
            lsu_req  <= 1'b0;
            lsu_we   <= 1'b0;
            reg_we   <= 1'b0;
            pc_we    <= 1'b0;
            pc_sel   <= 1'b0;
            halt     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            pc_we  <= 1'b0;
            pc_sel <= 1'b0;
            case (state)
                S_RST: begin
                    state   <= S_FETCH;
                    ifu_req <= 1'b1;
                end
                S_FETCH: begin
                    if (ifu_ack) begin
                        ir      <= ifu_rdata;
                        ifu_req <= 1'b0;
                        state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    type_o <= dec_type;
                    if (ir == EBREAK) begin
                        state    <= S_HALT;
                        halt     <= 1'b1;
                        inst_cnt <= inst_cnt + 32'd1;
                    end else if (dec_bad) begin
                        state   <= S_HALT;
                        halt    <= 1'b1;
                        illegal <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_mem) begin
                        state   <= S_MEM;
                        lsu_req <= 1'b1;
                        lsu_we  <= (opcode == OP_STORE);
                    end else begin
                        state  <= S_WB;
                        pc_we  <= 1'b1;
                        reg_we <= wb_reg_we;
                        pc_sel <= wb_pc_sel;
                    end
                end
                S_MEM: begin
                    if (lsu_ack) begin
                        state   <= S_WB;
                        lsu_req <= 1'b0;
                        lsu_we  <= 1'b0;
                        pc_we   <= 1'b1;
                        reg_we  <= wb_reg_we;
                        pc_sel  <= wb_pc_sel;
                    end
                end
                S_WB: begin
                    state    <= S_FETCH;
                    ifu_req  <= 1'b1;
                    inst_cnt <= inst_cnt + 32'd1;
                end
                default: begin
                    state <= S_HALT;
                end
            endcase
        end
    end
endmodule
